// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall controller for the five-stage pipeline.
// Define FWD_POSTWB_BYPASS_EN to add the post-writeback tag stage and the 11 select code.
module fwd_hazard_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_rs_used_i,
  input  logic             id_rt_used_i,
  input  logic [REG_W-1:0] id_rd_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic [1:0]       fwd_a_sel_o,
  output logic [1:0]       fwd_b_sel_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic             memread;
    logic [REG_W-1:0] rd;
  } tag_t;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  localparam tag_t TAG_BUBBLE = '{valid: 1'b0, regwrite: 1'b0, memread: 1'b0, rd: {REG_W{1'b0}}};

`ifdef FWD_POSTWB_BYPASS_EN
  localparam logic [1:0] WB_SEL = 2'b11;
`else
  // Register file is write-before-read, so a WB producer needs no bypass.
  localparam logic [1:0] WB_SEL = 2'b00;
`endif

  tag_t   ex_tag_r;
  tag_t   mem_tag_r;
  tag_t   wb_tag_r;
`ifdef FWD_POSTWB_BYPASS_EN
  tag_t   post_tag_r;
`endif
  state_t state_r;

  tag_t       id_tag_s;
  logic [1:0] sel_a_s;
  logic [1:0] sel_b_s;
  logic       hazard_s;
  logic       load_ex_s;

  function automatic logic tag_match(input tag_t t, input logic [REG_W-1:0] src, input logic used);
    return t.valid & t.regwrite & used & (t.rd == src) & (t.rd != {REG_W{1'b0}});
  endfunction

  function automatic logic [1:0] sel_for(input tag_t ex_t, input tag_t mem_t, input tag_t wb_t,
                                         input logic [REG_W-1:0] src, input logic used);
    logic [1:0] sel;
    if (tag_match(ex_t, src, used)) begin
      sel = 2'b01;
    end else if (tag_match(mem_t, src, used)) begin
      sel = 2'b10;
    end else if (tag_match(wb_t, src, used)) begin
      sel = WB_SEL;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Select resolution, load-use detection and EX-load decision for the ID instruction
  always_comb begin
    id_tag_s  = '{valid: id_valid_i, regwrite: id_regwrite_i, memread: id_memread_i, rd: id_rd_i};
    sel_a_s   = sel_for(ex_tag_r, mem_tag_r, wb_tag_r, id_rs_i, id_rs_used_i);
    sel_b_s   = sel_for(ex_tag_r, mem_tag_r, wb_tag_r, id_rt_i, id_rt_used_i);
    hazard_s  = id_valid_i & ex_tag_r.memread &
                (tag_match(ex_tag_r, id_rs_i, id_rs_used_i) | tag_match(ex_tag_r, id_rt_i, id_rt_used_i));
    // Flush wins over the stall; STALL state blocks a second consecutive stall.
    stall_o   = hazard_s & ~flush_i & (state_r == RUN) & ~rst_i;
    load_ex_s = id_valid_i & ~stall_o & ~flush_i;
  end

  // Tag pipeline shift, registered selects, FSM and saturating stall counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_tag_r    <= TAG_BUBBLE;
      mem_tag_r   <= TAG_BUBBLE;
      wb_tag_r    <= TAG_BUBBLE;
`ifdef FWD_POSTWB_BYPASS_EN
      post_tag_r  <= TAG_BUBBLE;
`endif
      state_r     <= RUN;
      fwd_a_sel_o <= 2'b00;
      fwd_b_sel_o <= 2'b00;
      stall_cnt_o <= {CNT_W{1'b0}};
    end else begin
`ifdef FWD_POSTWB_BYPASS_EN
      post_tag_r  <= wb_tag_r;
`endif
      wb_tag_r    <= mem_tag_r;
      mem_tag_r   <= ex_tag_r;
      ex_tag_r    <= load_ex_s ? id_tag_s : TAG_BUBBLE;
      fwd_a_sel_o <= load_ex_s ? sel_a_s : 2'b00;
      fwd_b_sel_o <= load_ex_s ? sel_b_s : 2'b00;
      if (stall_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
        stall_cnt_o <= stall_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_o <= stall_cnt_o;
      end
      case (state_r)
        RUN:     state_r <= stall_o ? STALL : RUN;
        STALL:   state_r <= RUN;
        default: state_r <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed scoreboard bench for fwd_hazard_unit; a narrow stall counter exposes saturation.
module tb_fwd_hazard_unit;

  localparam int REG_W = 5;
  localparam int CNT_W = 2;

`ifdef FWD_POSTWB_BYPASS_EN
  localparam logic [1:0] WB_EXP = 2'b11;
`else
  localparam logic [1:0] WB_EXP = 2'b00;
`endif

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             id_valid_i;
  logic [REG_W-1:0] id_rs_i;
  logic [REG_W-1:0] id_rt_i;
  logic             id_rs_used_i;
  logic             id_rt_used_i;
  logic [REG_W-1:0] id_rd_i;
  logic             id_regwrite_i;
  logic             id_memread_i;
  logic             flush_i;
  logic             stall_o;
  logic [1:0]       fwd_a_sel_o;
  logic [1:0]       fwd_b_sel_o;
  logic [CNT_W-1:0] stall_cnt_o;

  typedef struct {
    string      name;
    logic [1:0] a;
    logic [1:0] b;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  logic [CNT_W-1:0] cnt_model = '0;

  fwd_hazard_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_rs_used_i(id_rs_used_i), .id_rt_used_i(id_rt_used_i),
    .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .flush_i(flush_i), .stall_o(stall_o),
    .fwd_a_sel_o(fwd_a_sel_o), .fwd_b_sel_o(fwd_b_sel_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called just after a rising edge: present one ID instruction, check the same-cycle stall,
  // then after the next edge check the registered selects and counter for that instruction.
  task automatic step(input string name, input logic rst, input logic v,
                      input logic [4:0] rs, input logic rsu, input logic [4:0] rt, input logic rtu,
                      input logic [4:0] rd, input logic rw, input logic mr, input logic fl,
                      input logic exp_stall, input logic [1:0] ea, input logic [1:0] eb);
    exp_t e;
    rst_i = rst; id_valid_i = v; id_rs_i = rs; id_rs_used_i = rsu; id_rt_i = rt;
    id_rt_used_i = rtu; id_rd_i = rd; id_regwrite_i = rw; id_memread_i = mr; flush_i = fl;
    #3;
    chk({name, ".stall"}, {15'd0, stall_o}, {15'd0, exp_stall});
    if (rst) cnt_model = '0;
    else if (exp_stall && cnt_model != {CNT_W{1'b1}}) cnt_model = cnt_model + 2'd1;
    e.name = name; e.a = ea; e.b = eb; e.cnt = cnt_model;
    exp_q.push_back(e);
    @(posedge clk_i); #1;
    e = exp_q.pop_front();
    chk({e.name, ".sel_a"}, {14'd0, fwd_a_sel_o}, {14'd0, e.a});
    chk({e.name, ".sel_b"}, {14'd0, fwd_b_sel_o}, {14'd0, e.b});
    chk({e.name, ".cnt"}, {14'd0, stall_cnt_o}, {14'd0, e.cnt});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step("idle", 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
  endtask

  initial begin
    rst_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      {id_valid_i, id_rs_used_i, id_rt_used_i, id_regwrite_i, id_memread_i, flush_i} = 6'($urandom);
      id_rs_i = 5'($urandom); id_rt_i = 5'($urandom); id_rd_i = 5'($urandom);
      if (c < 2) begin @(posedge clk_i); #1; end
    end
    chk("reset.stall", {15'd0, stall_o}, 16'd0);
    chk("reset.sel_a", {14'd0, fwd_a_sel_o}, 16'd0);
    chk("reset.sel_b", {14'd0, fwd_b_sel_o}, 16'd0);
    chk("reset.cnt", {14'd0, stall_cnt_o}, 16'd0);

    //    name             rst   v     rs    u     rt    u     rd    rw    mr    fl    stall ea     eb
    step("add_r3",         1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step("sub_rs_r3",      1'b0, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
    idle(3);
    step("lw_r5",          1'b0, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    step("lu_stall",       1'b0, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
    step("lu_resume",      1'b0, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10);
    idle(3);
    step("w_r7_d2",        1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step("w_r7_d1",        1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step("rd_r7_prio",     1'b0, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01);
    idle(3);
    step("w_r7_d3",        1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    idle(2);
    step("rd_r7_wb",       1'b0, 1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, WB_EXP, 2'b00);
    idle(3);
    step("lw_r10",         1'b0, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    step("haz_flush",      1'b0, 1'b1, 5'd10, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    step("after_flush",    1'b0, 1'b1, 5'd10, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);
    idle(3);
    step("add_r0",         1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step("read_r0",        1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step("lw_r0",          1'b0, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    step("read_r0_lw",     1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    idle(3);
    step("lw_r11",         1'b0, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    step("unused_rt_r11",  1'b0, 1'b1, 5'd2, 1'b1, 5'd11, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    idle(3);
    step("lw_r12",         1'b0, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    step("rst_mid_haz",    1'b1, 1'b1, 5'd12, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step("post_rst_read",  1'b0, 1'b1, 5'd12, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    for (int k = 0; k < 4; k++) begin
      step("sat_lw_r5",    1'b0, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
      step("sat_stall",    1'b0, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
      step("sat_resume",   1'b0, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10);
    end
    idle(1);
    chk("sat.cnt_final", {14'd0, stall_cnt_o}, 16'd3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Forwarding and load-use hazard controller for the five-stage pipelined CPU. Tracks destination-register tags of in-flight instructions in an internal tag pipeline that mirrors EX/MEM/WB. Produces registered 2-bit select codes that drive the operand-A and operand-B 4-to-1 forwarding multiplexers in EX, plus a one-cycle load-use stall request to IF/ID. Sits in ID, directly upstream of the EX forwarding multiplexers.

## Interface
- `REG_W`, default 5: register-index width.
- `CNT_W`, default 16: stall-counter width.
- `clk_i` in 1: clock; all state updates on rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `id_valid_i` in 1: instruction in ID is valid.
- `id_rs_i` / `id_rt_i` in REG_W: source register indices of the ID instruction.
- `id_rs_used_i` / `id_rt_used_i` in 1: the corresponding source is actually read.
- `id_rd_i` in REG_W: destination index of the ID instruction.
- `id_regwrite_i` in 1: ID instruction writes `id_rd_i`.
- `id_memread_i` in 1: ID instruction is a load.
- `flush_i` in 1: taken branch; kills the ID instruction.
- `stall_o` out 1: hold PC and IF/ID; insert a bubble into ID/EX.
- `fwd_a_sel_o` / `fwd_b_sel_o` out 2: registered select for the EX operand-A/B forwarding multiplexers. Codes:
  - 00: ID/EX register data
  - 01: EX/MEM ALU result
  - 10: MEM/WB write data
  - 11: post-WB held data
- `stall_cnt_o` out CNT_W: saturating count of stall cycles.

## Operation
- Tag record: {valid, regwrite, memread, rd}. Four stages are kept: `ex_tag`, `mem_tag`, `wb_tag`, `post_tag`.
- Every cycle the tags shift: `post<=wb`, `wb<=mem`, `mem<=ex`.
- `ex_tag` loads the ID record when `id_valid_i & !stall_o & !flush_i`. Otherwise `ex_tag` loads a bubble (all fields 0).
- A tag matches source s when all of these hold: valid, regwrite, rd==s, rd!=0, and the source-used flag is set.
- Select priority for each source, evaluated in ID, newest producer first:
  - `ex_tag` match → 01
  - else `mem_tag` match → 10
  - else `wb_tag` match → 11
  - else 00
- Load-use hazard: `ex_tag.memread` and an `ex_tag` match on either used source, with `id_valid_i`. Then `stall_o`=1, provided `flush_i`=0.
- State machine: RUN and STALL.
  - RUN→STALL on hazard.
  - STALL→RUN unconditionally after one cycle. The bubble guarantees the load is then in `mem_tag` and the select resolves to 10.
  - `stall_o` may not assert in STALL; back-to-back hazards require passing through RUN.
- `flush_i` has priority over the stall: no stall is asserted, and the bubble enters EX.
- `stall_cnt_o` increments on every cycle with `stall_o`=1 and saturates at all-ones.

## Timing
- Select outputs are registered and update on the edge that moves the ID instruction into EX. They are therefore valid for the whole EX cycle of that instruction.
- When a bubble is loaded (stall, flush, or invalid ID), the selects register to 00.
- `stall_o` is combinational from the current tags and ID inputs. It is valid in the same cycle.
- Reset values: all tags invalid, FSM=RUN, `fwd_a_sel_o`=`fwd_b_sel_o`=00, `stall_o`=0, `stall_cnt_o`=0.
- Reset asserted mid-stall returns the block to RUN on the same edge. No stale forwarding survives reset.
- A source of r0 never forwards and never stalls.

## Configuration
- `FWD_POSTWB_BYPASS_EN` defined:
  - `post_tag` is implemented.
  - A `wb_tag` match yields 11, so EX reads the value held one cycle after writeback.
- Not defined:
  - `post_tag` is removed.
  - A `wb_tag` match yields 00, because the register file is write-before-read.
  - Code 11 is never produced.

## Test plan
- Reset: hold `rst_i`=1 for 2 cycles with random inputs → selects 00, `stall_o`=0, `stall_cnt_o`=0.
- EX/MEM forwarding: `add r3` followed immediately by `sub` reading rs=r3 → `fwd_a_sel_o`=01 during the sub's EX cycle; `fwd_b_sel_o`=00.
- Load-use: `lw r5` followed by `add` with rt=r5 → `stall_o`=1 for exactly one cycle. Next cycle the add's `fwd_b_sel_o`=10, and `stall_cnt_o`=1.
- Priority: writes to r7 at distances 1 and 2, then a read of r7 → 01. A writer at distance 3 only → 11 with the macro, 00 without it.
- Flush and r0:
  - Hazard with `flush_i`=1 → `stall_o`=0 and the selects register to 00.
  - `add r0` followed by a read of r0 → select 00, no stall.
